// File: rtl/painterengine_gpu_pkg.sv
// Shared definitions for the GPU DVI pixel fetch path.
// Fetch FSM encodings and pixel word size.
package painterengine_gpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        DATA,
        DRAIN
    } fetch_state_t;

    localparam int unsigned BYTES_PER_PIXEL = 4;

endpackage

// File: rtl/painterengine_gpu_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Head word is visible combinationally; reads 0 while empty.
module painterengine_gpu_sync_fifo #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                     i_wire_pixel_clock,
    input  logic                     i_wire_resetn,
    input  logic                     i_wire_flush,
    input  logic                     i_wire_push,
    input  logic [WIDTH-1:0]         i_wire_wdata,
    input  logic                     i_wire_pop,
    output logic [WIDTH-1:0]         o_wire_rdata,
    output logic                     o_wire_full,
    output logic                     o_wire_empty,
    output logic [$clog2(DEPTH):0]   o_wire_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic             do_push;
    logic             do_pop;

    assign o_wire_full  = (level == LW'(DEPTH));
    assign o_wire_empty = (level == '0);
    assign o_wire_level = level;
    assign o_wire_rdata = o_wire_empty ? '0 : mem[rd_ptr];

    assign do_push = i_wire_push && !o_wire_full && !i_wire_flush;
    assign do_pop  = i_wire_pop && !o_wire_empty && !i_wire_flush;

    always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (i_wire_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge i_wire_pixel_clock) begin
        if (do_push) mem[wr_ptr] <= i_wire_wdata;
    end

endmodule

// File: rtl/painterengine_gpu_dvi_pixel_fetch.sv
// Frame prefetch ahead of the DVI timing generator.
// Bursts framebuffer words into a FWFT FIFO, one burst in flight.
module painterengine_gpu_dvi_pixel_fetch
    import painterengine_gpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 256,
    parameter int BURST_LEN  = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_wire_pixel_clock,
    input  logic                  i_wire_resetn,
    input  logic                  i_wire_start,
    input  logic [ADDR_WIDTH-1:0] i_wire_base_addr,
    input  logic [15:0]           i_wire_clip_width,
    input  logic [15:0]           i_wire_clip_height,
    output logic                  o_wire_rd_req,
    output logic [ADDR_WIDTH-1:0] o_wire_rd_addr,
    output logic [7:0]            o_wire_rd_len,
    input  logic                  i_wire_rd_ack,
    input  logic                  i_wire_rd_valid,
    input  logic [31:0]           i_wire_rd_data,
    input  logic                  i_wire_next_rgb,
    output logic [31:0]           o_wire_rgba,
    output logic                  o_wire_busy,
    output logic                  o_wire_done,
    output logic                  o_wire_underflow
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t          state_q;
    fetch_state_t          state_d;
    logic [31:0]           total_q;
    logic [31:0]           remaining_q;
    logic [31:0]           popped_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beats_q;
    logic                  req_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  underflow_q;

    logic [LW-1:0]         fifo_level;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  pop_fire;

    logic [31:0]           total_w;
    logic [31:0]           outstanding_w;
    logic [31:0]           free_w;
    logic [7:0]            burst_w;
    logic                  load;
    logic                  issue;
    logic                  ack_fire;
    logic                  finish;

    assign total_w = 32'(i_wire_clip_width) * 32'(i_wire_clip_height);

    always_comb begin
        outstanding_w = '0;
        unique case (state_q)
            WAIT_ACK: outstanding_w = 32'(len_q);
            DATA:     outstanding_w = 32'(beats_q);
            default:  outstanding_w = '0;
        endcase
    end

    assign free_w  = 32'(FIFO_DEPTH) - 32'(fifo_level) - outstanding_w;
    assign burst_w = (remaining_q < 32'(BURST_LEN)) ? remaining_q[7:0]
                                                   : 8'(BURST_LEN);

    // Pops past the frame end are dropped so done stays coherent.
    assign pop_fire  = i_wire_next_rgb && (popped_q < total_q);
    assign fifo_push = (state_q == DATA) && i_wire_rd_valid;

    always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) state_q <= IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        issue    = 1'b0;
        ack_fire = 1'b0;
        finish   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_wire_start) begin
                    load    = 1'b1;
                    state_d = (total_w == '0) ? IDLE : ISSUE;
                end
            end
            ISSUE: begin
                if (remaining_q != '0 && !fifo_full &&
                    free_w >= 32'(BURST_LEN)) begin
                    issue   = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (i_wire_rd_ack) begin
                    ack_fire = 1'b1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (i_wire_rd_valid && beats_q == 8'd1)
                    state_d = (remaining_q != '0) ? ISSUE : DRAIN;
            end
            DRAIN: begin
                if (popped_q == total_q) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            total_q     <= '0;
            remaining_q <= '0;
            popped_q    <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            beats_q     <= '0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (pop_fire) begin
                popped_q <= popped_q + 32'd1;
                if (fifo_empty) underflow_q <= 1'b1;
            end
            if (issue) begin
                req_q <= 1'b1;
                len_q <= burst_w;
            end
            if (ack_fire) begin
                req_q       <= 1'b0;
                addr_q      <= addr_q + ADDR_WIDTH'(len_q) *
                               ADDR_WIDTH'(BYTES_PER_PIXEL);
                remaining_q <= remaining_q - 32'(len_q);
                beats_q     <= len_q;
            end
            if (fifo_push) beats_q <= beats_q - 8'd1;
            if (finish) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
            if (load) begin
                total_q     <= total_w;
                remaining_q <= total_w;
                popped_q    <= '0;
                addr_q      <= i_wire_base_addr;
                underflow_q <= 1'b0;
                done_q      <= (total_w == '0);
                busy_q      <= (total_w != '0);
            end
        end
    end

    painterengine_gpu_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_wire_pixel_clock (i_wire_pixel_clock),
        .i_wire_resetn      (i_wire_resetn),
        .i_wire_flush       (load),
        .i_wire_push        (fifo_push),
        .i_wire_wdata       (i_wire_rd_data),
        .i_wire_pop         (pop_fire),
        .o_wire_rdata       (o_wire_rgba),
        .o_wire_full        (fifo_full),
        .o_wire_empty       (fifo_empty),
        .o_wire_level       (fifo_level)
    );

    assign o_wire_rd_req    = req_q;
    assign o_wire_rd_addr   = addr_q;
    assign o_wire_rd_len    = len_q;
    assign o_wire_busy      = busy_q;
    assign o_wire_done      = done_q;
    assign o_wire_underflow = underflow_q;

endmodule

// File: tb/tb_painterengine_gpu_dvi_pixel_fetch.sv
// Scoreboard bench for the DVI pixel fetch stage.
// Memory model returns word = byte address; FIFO_DEPTH=32, BURST_LEN=16.
module tb_painterengine_gpu_dvi_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] clip_w;
    logic [15:0] clip_h;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_ack;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        next_rgb;
    logic [31:0] rgba;
    logic        busy;
    logic        done;
    logic        underflow;

    logic        cons_pop = 1'b0;
    logic        force_pop = 1'b0;
    logic        tb_clear = 1'b0;
    logic        free_run = 1'b0;
    logic        mem_active = 1'b0;
    int          budget = 0;
    int          ack_delay = 0;
    int          pushed = 0;
    int          popped = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic [39:0] exp_req[$];
    logic [31:0] exp_pix[$];

    always #5 clk = ~clk;
    assign next_rgb = cons_pop | force_pop;

    painterengine_gpu_dvi_pixel_fetch #(
        .FIFO_DEPTH (32),
        .BURST_LEN  (16),
        .ADDR_WIDTH (32)
    ) dut (
        .i_wire_pixel_clock (clk),
        .i_wire_resetn      (rst_n),
        .i_wire_start       (start),
        .i_wire_base_addr   (base_addr),
        .i_wire_clip_width  (clip_w),
        .i_wire_clip_height (clip_h),
        .o_wire_rd_req      (rd_req),
        .o_wire_rd_addr     (rd_addr),
        .o_wire_rd_len      (rd_len),
        .i_wire_rd_ack      (rd_ack),
        .i_wire_rd_valid    (rd_valid),
        .i_wire_rd_data     (rd_data),
        .i_wire_next_rgb    (next_rgb),
        .o_wire_rgba        (rgba),
        .o_wire_busy        (busy),
        .o_wire_done        (done),
        .o_wire_underflow   (underflow)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_pix(input logic [31:0] b, input int n);
        for (int i = 0; i < n; i++) exp_pix.push_back(b + 32'(4 * i));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input logic [31:0] b, input logic [15:0] w,
                               input logic [15:0] h);
        base_addr = b;
        clip_w    = w;
        clip_h    = h;
        start     = 1'b1;
        tb_clear  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        tb_clear = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    task automatic drained(input string name);
        check({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
        check({name, "_pix_left"}, 32'(exp_pix.size()), 32'd0);
    endtask

    // Pushes/pops as the DUT sees them, counted at the active edge.
    always @(posedge clk) begin
        if (tb_clear) begin
            pushed <= 0;
            popped <= 0;
        end else begin
            if (rd_valid) pushed <= pushed + 1;
            if (cons_pop) popped <= popped + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && dut.fifo_push && dut.u_fifo.o_wire_full) begin
            vectors++;
            miscompares++;
            $display("FAIL fifo_push_on_full: got 1 expected 0");
        end
    end

    initial begin : memory_model
        logic [31:0] a;
        logic [7:0]  l;
        logic        unstable;
        rd_ack   = 1'b0;
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rd_req && rst_n) begin
                a = rd_addr;
                l = rd_len;
                unstable = 1'b0;
                mem_active = 1'b1;
                for (int k = 0; k < ack_delay; k++) begin
                    @(negedge clk);
                    if (!rd_req || rd_addr !== a || rd_len !== l)
                        unstable = 1'b1;
                end
                check("req_stable", 32'(unstable), 32'd0);
                rd_ack = 1'b1;
                @(negedge clk);
                rd_ack = 1'b0;
                check("req_drop", 32'(rd_req), 32'd0);
                for (int i = 0; i < int'(l); i++) begin
                    if (i % 5 == 3) begin
                        rd_valid = 1'b0;
                        @(negedge clk);
                    end
                    rd_valid = 1'b1;
                    rd_data  = a + 32'(4 * i);
                    @(negedge clk);
                end
                rd_valid   = 1'b0;
                mem_active = 1'b0;
            end
        end
    end

    initial begin : req_monitor
        logic        prev = 1'b0;
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (rd_req && !prev) begin
                if (exp_req.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL req_unexpected: got %h/%0d expected none",
                             rd_addr, rd_len);
                end else begin
                    e = exp_req.pop_front();
                    check("req_addr", rd_addr, e[39:8]);
                    check("req_len", 32'(rd_len), 32'(e[7:0]));
                    check("req_free_space",
                          32'((32 - (pushed - popped)) >= 16), 32'd1);
                end
            end
            prev = rd_req;
        end
    end

    initial begin : pixel_monitor
        forever begin
            @(negedge clk);
            cons_pop = 1'b0;
            if ((free_run || budget > 0) && pushed > popped && !tb_clear) begin
                if (exp_pix.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pixel_unexpected: got %h expected none",
                             rgba);
                end else begin
                    check("pixel", rgba, exp_pix.pop_front());
                end
                cons_pop = 1'b1;
                if (!free_run) budget--;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        start     = 1'b0;
        base_addr = '0;
        clip_w    = '0;
        clip_h    = '0;
        cycles(3);
        #1;
        check("rst_req", 32'(rd_req), 32'd0);
        check("rst_addr", rd_addr, 32'd0);
        check("rst_len", 32'(rd_len), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_rgba", rgba, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);

        // 4x2 frame: one 8-word burst
        exp_req.push_back({32'h1000, 8'd8});
        push_pix(32'h1000, 8);
        free_run = 1'b1;
        start_frame(32'h1000, 16'd4, 16'd2);
        check("t1_busy_set", 32'(busy), 32'd1);
        wait_done("t1", 500);
        check("t1_underflow", 32'(underflow), 32'd0);
        free_run = 1'b0;
        drained("t1");

        // 40x1 frame: 16 + 16 + 8
        exp_req.push_back({32'h0, 8'd16});
        exp_req.push_back({32'h40, 8'd16});
        exp_req.push_back({32'h80, 8'd8});
        push_pix(32'h0, 40);
        free_run = 1'b1;
        start_frame(32'h0, 16'd40, 16'd1);
        wait_done("t2", 1000);
        free_run = 1'b0;
        drained("t2");

        // 48x1 frame with a stalled consumer
        exp_req.push_back({32'h2000, 8'd16});
        exp_req.push_back({32'h2040, 8'd16});
        exp_req.push_back({32'h2080, 8'd16});
        push_pix(32'h2000, 48);
        start_frame(32'h2000, 16'd48, 16'd1);
        cycles(100);
        check("t3_buffered", 32'(pushed), 32'd32);
        check("t3_stall_req", 32'(rd_req), 32'd0);
        budget = 15;
        cycles(40);
        check("t3_15pop_req", 32'(rd_req), 32'd0);
        check("t3_15pop_pending", 32'(exp_req.size()), 32'd1);
        budget = 1;
        n = 0;
        while (exp_req.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t3_release", 32'(exp_req.size()), 32'd0);
        free_run = 1'b1;
        wait_done("t3", 1000);
        free_run = 1'b0;
        drained("t3");

        // Pop on empty FIFO mid-frame
        ack_delay = 10;
        exp_req.push_back({32'h3000, 8'd4});
        push_pix(32'h3000, 3);
        start_frame(32'h3000, 16'd4, 16'd1);
        cycles(3);
        check("t4_rgba_empty", rgba, 32'd0);
        force_pop = 1'b1;
        @(negedge clk);
        force_pop = 1'b0;
        check("t4_underflow_set", 32'(underflow), 32'd1);
        check("t4_rgba_after", rgba, 32'd0);
        budget = 3;
        wait_done("t4", 500);
        check("t4_underflow_sticky", 32'(underflow), 32'd1);
        drained("t4");

        // Delayed ack, start while busy ignored
        ack_delay = 5;
        exp_req.push_back({32'h4000, 8'd16});
        push_pix(32'h4000, 16);
        free_run = 1'b1;
        start_frame(32'h4000, 16'd16, 16'd1);
        cycles(2);
        base_addr = 32'h9000;
        clip_w    = 16'd2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_busy_hold", 32'(busy), 32'd1);
        wait_done("t5", 500);
        check("t5_underflow_clr", 32'(underflow), 32'd0);
        free_run = 1'b0;
        drained("t5");

        // Reset during DATA, then zero-size and fresh frames
        ack_delay = 0;
        exp_req.push_back({32'h5000, 8'd16});
        start_frame(32'h5000, 16'd16, 16'd1);
        n = 0;
        while (pushed < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_in_data", 32'(dut.state_q), 32'(painterengine_gpu_pkg::DATA));
        rst_n = 1'b0;
        #1;
        check("t6_req", 32'(rd_req), 32'd0);
        check("t6_addr", rd_addr, 32'd0);
        check("t6_len", 32'(rd_len), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_rgba", rgba, 32'd0);
        cycles(2);
        rst_n = 1'b1;
        n = 0;
        while (mem_active && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_late_beats_idle", 32'(busy), 32'd0);
        start_frame(32'h7000, 16'd0, 16'd5);
        check("t6_zero_done", 32'(done), 32'd1);
        check("t6_zero_busy", 32'(busy), 32'd0);
        cycles(5);
        check("t6_zero_req", 32'(rd_req), 32'd0);
        exp_req.push_back({32'h6000, 8'd4});
        push_pix(32'h6000, 4);
        free_run = 1'b1;
        start_frame(32'h6000, 16'd4, 16'd1);
        wait_done("t6", 500);
        check("t6_underflow", 32'(underflow), 32'd0);
        free_run = 1'b0;
        drained("t6");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/painterengine_gpu_dvi_pixel_fetch.md
Name: painterengine_gpu_dvi_pixel_fetch

Overview:
Prefetch stage directly upstream of the GPU DVI timing generator. It reads a clip_width x clip_height framebuffer of 32-bit pixels from memory in bursts and buffers them in a FIFO. It presents the head pixel continuously on o_wire_rgba and pops one entry per i_wire_next_rgb pulse from the timing generator. Everything runs in the pixel clock domain.

Parameters:
FIFO_DEPTH, 256, pixel FIFO entries; power of two, at least 2*BURST_LEN.
BURST_LEN, 16, maximum words per memory read burst; range 1..255.
ADDR_WIDTH, 32, memory byte-address width.

Ports:
i_wire_pixel_clock  in  1  pixel clock; all logic on its rising edge.
i_wire_resetn  in  1  asynchronous active-low reset.
i_wire_start  in  1  one-cycle pulse; starts a frame fetch when idle.
i_wire_base_addr  in  ADDR_WIDTH  frame byte base address; must be 4-byte aligned; sampled at start.
i_wire_clip_width  in  16  pixels per line; sampled at start.
i_wire_clip_height  in  16  lines; sampled at start.
o_wire_rd_req  out  1  burst read request; held until acknowledged.
o_wire_rd_addr  out  ADDR_WIDTH  burst start byte address.
o_wire_rd_len  out  8  burst length in words, 1..BURST_LEN.
i_wire_rd_ack  in  1  request accepted.
i_wire_rd_valid  in  1  read data beat valid.
i_wire_rd_data  in  32  read data beat.
i_wire_next_rgb  in  1  consumer pop: the current o_wire_rgba has been taken.
o_wire_rgba  out  32  head pixel (first-word-fall-through); 0 when the FIFO is empty.
o_wire_busy  out  1  frame fetch in progress.
o_wire_done  out  1  sticky; all pixels of the frame popped.
o_wire_underflow  out  1  sticky; a pop occurred while the FIFO was empty.

Behaviour:
- Reset values: rd_req=0, rd_addr=0, rd_len=0, busy=0, done=0, underflow=0, FIFO empty, rgba=0, FSM in IDLE.
- total = clip_width*clip_height, computed at 32 bits at start. A value of 0 sets done=1 the next cycle and issues no requests.
- FSM states:
  - IDLE: on start, latch the config, clear done and underflow, set remaining=total and addr=base, go to ISSUE.
  - ISSUE: waits until remaining>0 and free space >= BURST_LEN. Free space counts outstanding (requested but not yet received) words. Then asserts rd_req with len=min(BURST_LEN, remaining) and goes to WAIT_ACK.
  - WAIT_ACK: rd_req/addr/len are held stable until rd_ack. On ack: rd_req drops the next cycle, addr+=4*len, remaining-=len, beats=len, go to DATA. An ack in the same cycle req first rises is accepted.
  - DATA: each rd_valid pushes rd_data into the FIFO and decrements beats. On the last beat go to ISSUE if remaining>0, otherwise DRAIN.
  - DRAIN: when popped count == total, set done=1, busy=0, go to IDLE.
- Only one burst is outstanding at a time. rd_valid outside DATA is ignored.
- busy=1 from the cycle after start until done is set.
- start while busy is ignored.
- FIFO: push and pop in the same cycle keep the level unchanged. Pushing on full cannot occur by construction; the bench asserts on it.
- Pop with the FIFO empty: no state change other than underflow<=1 (sticky until the next start). The popped count still increments, so the frame still completes.
- o_wire_rgba is combinational from the FIFO head; next_rgb at cycle t advances the head visible at t+1.
- Popped count saturates at total; pops beyond it are ignored and leave underflow unchanged.
- Asynchronous reset mid-burst: all state clears immediately. Late rd_valid beats after reset are dropped because the FSM is in IDLE.

Decomposition:
- Shared package painterengine_gpu_pkg holds the FSM state encodings (IDLE, ISSUE, WAIT_ACK, DATA, DRAIN) and the word-size constant BYTES_PER_PIXEL=4.
- Sub-module: painterengine_gpu_sync_fifo, a single-clock FWFT FIFO with parameters DEPTH and WIDTH, and outputs full, empty and level. This module instantiates it once.

Test Plan:
- Reset, then width=4, height=2, base=0x1000, memory returns word = address. Required: bursts (0x1000, len 8) only; rgba sequence 0x1000..0x101C over 8 pops; done=1; underflow=0.
- width=40, height=1, BURST_LEN=16. Required: requests at 0x0/16, 0x40/16, 0x80/8; no request issued while free space < 16.
- Consumer stalls (no next_rgb) with FIFO_DEPTH=32. Required: at most 32 words buffered, rd_req stays low until pops free 16 entries.
- next_rgb pulsed on an empty FIFO mid-frame. Required: underflow=1 and sticky, rgba=0, and the frame still completes with done=1 after total pops.
- rd_ack delayed 5 cycles. Required: rd_req/addr/len stable throughout, and a start pulse during busy has no effect.
- Reset asserted during the DATA state of a 16-beat burst. Required: outputs return to reset values asynchronously, then a fresh start fetches correctly from the new base.
